// File: rtl/png_chunk_chk.sv
// png_chunk_chk: PNG stream parser. Checks the signature, walks the chunk
// headers, recomputes CRC-32 over type+data, captures the IHDR size and
// forwards IDAT payload bytes downstream.
module png_chunk_chk #(
  parameter int unsigned DATA_WD     = 8,
  parameter int unsigned SIZE_PIC_WD = 32,
  parameter logic [31:0] MAX_LEN     = 32'h7FFF_FFFF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic                   val_i,
  input  logic [DATA_WD-1:0]     dat_i,
  output logic                   busy_o,
  output logic                   hdr_val_o,
  output logic [31:0]            typ_o,
  output logic [SIZE_PIC_WD-1:0] len_o,
  output logic [SIZE_PIC_WD-1:0] w_o,
  output logic [SIZE_PIC_WD-1:0] h_o,
  output logic                   val_o,
  output logic [DATA_WD-1:0]     dat_o,
  output logic                   lst_o,
  output logic                   crc_val_o,
  output logic                   crc_err_o,
  output logic                   err_o,
  output logic [1:0]             err_code_o,
  output logic                   done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SIG,
    S_LEN,
    S_TYPE,
    S_DATA,
    S_CRC,
    S_ERR
  } state_t;

  localparam logic [31:0] TYP_IHDR = 32'h4948_4452;
  localparam logic [31:0] TYP_IDAT = 32'h4944_4154;
  localparam logic [31:0] TYP_IEND = 32'h4945_4E44;

  state_t                   r_state;
  state_t                   w_nxt;
  logic [3:0]               r_cnt;
  logic [SIZE_PIC_WD-1:0]   r_len_sh;
  logic [23:0]              r_typ_sh;
  logic [23:0]              r_crc_sh;
  logic [31:0]              r_crc;
  logic [SIZE_PIC_WD-1:0]   r_dcnt;

  logic                     w_sig_ok;
  logic                     w_fld_end;
  logic                     w_dat_last;
  logic                     w_crc_ok;
  logic                     w_is_iend;
  logic [SIZE_PIC_WD-1:0]   w_len_full;
  logic [31:0]              w_typ_full;
  logic [31:0]              w_crc_full;
  logic [31:0]              w_crc_upd;

  function automatic logic [7:0] sig_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'h89;
      3'd1:    return 8'h50;
      3'd2:    return 8'h4E;
      3'd3:    return 8'h47;
      3'd4:    return 8'h0D;
      3'd5:    return 8'h0A;
      3'd6:    return 8'h1A;
      default: return 8'h0A;
    endcase
  endfunction

  // Reflected CRC-32, one byte per call, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] x;
    x = c ^ {24'd0, d};
    for (int unsigned i = 0; i < 8; i++) begin
      x = x[0] ? ((x >> 1) ^ 32'hEDB8_8320) : (x >> 1);
    end
    return x;
  endfunction

  assign w_sig_ok   = (dat_i == sig_byte(r_cnt[2:0]));
  assign w_fld_end  = (r_cnt == 4'd3);
  assign w_dat_last = (r_dcnt == SIZE_PIC_WD'(1));
  assign w_len_full = {r_len_sh[SIZE_PIC_WD-DATA_WD-1:0], dat_i};
  assign w_typ_full = {r_typ_sh, dat_i};
  assign w_crc_full = {r_crc_sh, dat_i};
  assign w_crc_ok   = (w_crc_full == ~r_crc);
  assign w_crc_upd  = crc_byte(r_crc, dat_i);
  assign w_is_iend  = (typ_o == TYP_IEND);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  // Next-state decode; start_i overrides everything, val_i=0 holds.
  always_comb begin
    w_nxt = r_state;
    if (start_i) begin
      w_nxt = S_SIG;
    end else if (val_i) begin
      case (r_state)
        S_SIG: begin
          if (!w_sig_ok) begin
            w_nxt = S_ERR;
          end else if (r_cnt == 4'd7) begin
            w_nxt = S_LEN;
          end
        end
        S_LEN: begin
          if (w_fld_end) begin
            w_nxt = (w_len_full > MAX_LEN) ? S_ERR : S_TYPE;
          end
        end
        S_TYPE: begin
          if (w_fld_end) begin
            w_nxt = (r_len_sh != '0) ? S_DATA : S_CRC;
          end
        end
        S_DATA: begin
          if (w_dat_last) begin
            w_nxt = S_CRC;
          end
        end
        S_CRC: begin
          if (w_fld_end) begin
            if (!w_crc_ok) begin
              w_nxt = S_ERR;
            end else if (w_is_iend) begin
              w_nxt = S_IDLE;
            end else begin
              w_nxt = S_LEN;
            end
          end
        end
        default: w_nxt = r_state;
      endcase
    end
  end

  // Datapath: field shifters, CRC accumulation, counters and output pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_o     <= 1'b0;
      hdr_val_o  <= 1'b0;
      typ_o      <= '0;
      len_o      <= '0;
      w_o        <= '0;
      h_o        <= '0;
      val_o      <= 1'b0;
      dat_o      <= '0;
      lst_o      <= 1'b0;
      crc_val_o  <= 1'b0;
      crc_err_o  <= 1'b0;
      err_o      <= 1'b0;
      err_code_o <= 2'd0;
      done_o     <= 1'b0;
      r_cnt      <= '0;
      r_len_sh   <= '0;
      r_typ_sh   <= '0;
      r_crc_sh   <= '0;
      r_crc      <= '1;
      r_dcnt     <= '0;
    end else begin
      hdr_val_o <= 1'b0;
      val_o     <= 1'b0;
      lst_o     <= 1'b0;
      crc_val_o <= 1'b0;
      crc_err_o <= 1'b0;
      done_o    <= 1'b0;
      if (start_i) begin
        busy_o     <= 1'b1;
        err_o      <= 1'b0;
        err_code_o <= 2'd0;
        r_cnt      <= '0;
        r_dcnt     <= '0;
        r_crc      <= '1;
        w_o        <= '0;
        h_o        <= '0;
      end else if (val_i) begin
        case (r_state)
          S_SIG: begin
            if (!w_sig_ok) begin
              err_o      <= 1'b1;
              err_code_o <= 2'd1;
              busy_o     <= 1'b0;
              r_cnt      <= '0;
            end else if (r_cnt == 4'd7) begin
              r_cnt <= '0;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
          S_LEN: begin
            r_len_sh <= w_len_full;
            if (w_fld_end) begin
              r_cnt <= '0;
              if (w_len_full > MAX_LEN) begin
                err_o      <= 1'b1;
                err_code_o <= 2'd3;
                busy_o     <= 1'b0;
              end else begin
                r_crc <= '1;
              end
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
          S_TYPE: begin
            r_typ_sh <= w_typ_full[23:0];
            r_crc    <= w_crc_upd;
            if (w_fld_end) begin
              r_cnt     <= '0;
              typ_o     <= w_typ_full;
              len_o     <= r_len_sh;
              hdr_val_o <= 1'b1;
              r_dcnt    <= r_len_sh;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
          S_DATA: begin
            r_crc  <= w_crc_upd;
            r_dcnt <= r_dcnt - SIZE_PIC_WD'(1);
            if (typ_o == TYP_IDAT) begin
              val_o <= 1'b1;
              dat_o <= dat_i;
              lst_o <= w_dat_last;
            end
            if (typ_o == TYP_IHDR && r_cnt < 4'd8) begin
              if (r_cnt < 4'd4) begin
                w_o <= {w_o[SIZE_PIC_WD-DATA_WD-1:0], dat_i};
              end else begin
                h_o <= {h_o[SIZE_PIC_WD-DATA_WD-1:0], dat_i};
              end
              r_cnt <= r_cnt + 4'd1;
            end
            // Last-byte clear must win over the IHDR byte index increment.
            if (w_dat_last) begin
              r_cnt <= '0;
            end
          end
          S_CRC: begin
            r_crc_sh <= w_crc_full[23:0];
            if (w_fld_end) begin
              r_cnt     <= '0;
              crc_val_o <= 1'b1;
              crc_err_o <= !w_crc_ok;
              if (!w_crc_ok) begin
                err_o      <= 1'b1;
                err_code_o <= 2'd2;
                busy_o     <= 1'b0;
              end else if (w_is_iend) begin
                done_o <= 1'b1;
                busy_o <= 1'b0;
              end
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_png_chunk_chk.sv
module tb_png_chunk_chk;

  typedef logic [7:0] bq_t[$];

  localparam logic [31:0] T_IHDR = 32'h4948_4452;
  localparam logic [31:0] T_IDAT = 32'h4944_4154;
  localparam logic [31:0] T_IEND = 32'h4945_4E44;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        val_i = 1'b0;
  logic [7:0]  dat_i = 8'h00;
  logic        busy_o, hdr_val_o, val_o, lst_o, crc_val_o, crc_err_o, err_o, done_o;
  logic [31:0] typ_o, len_o, w_o, h_o;
  logic [7:0]  dat_o;
  logic [1:0]  err_code_o;

  always #5 clk = ~clk;

  png_chunk_chk #(
    .DATA_WD(8),
    .SIZE_PIC_WD(32),
    .MAX_LEN(32'h7FFF_FFFF)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .val_i(val_i), .dat_i(dat_i),
    .busy_o(busy_o), .hdr_val_o(hdr_val_o), .typ_o(typ_o), .len_o(len_o),
    .w_o(w_o), .h_o(h_o), .val_o(val_o), .dat_o(dat_o), .lst_o(lst_o),
    .crc_val_o(crc_val_o), .crc_err_o(crc_err_o), .err_o(err_o),
    .err_code_o(err_code_o), .done_o(done_o)
  );

  int unsigned n_checks = 0;
  int unsigned n_err = 0;

  logic [31:0] crc_tab [256];

  // Observed events, collected mid-cycle.
  logic [8:0]  got_pay[$];
  logic [31:0] got_typ[$];
  logic [31:0] got_len[$];
  logic        got_crc[$];
  int          got_done = 0;
  int          got_done_bad = 0;

  // Expected events, built from the chunk descriptions.
  logic [8:0]  exp_pay[$];
  logic [31:0] exp_typ[$];
  logic [31:0] exp_len[$];
  logic        exp_crc[$];
  int          b_pay, b_hdr, b_crc, b_done;

  bq_t strm;
  bq_t dq;
  bq_t sig_q = '{8'h89, 8'h50, 8'h4E, 8'h47, 8'h0D, 8'h0A, 8'h1A, 8'h0A};
  bq_t ihdr_q = '{8'h00, 8'h00, 8'h02, 8'h80, 8'h00, 8'h00, 8'h01, 8'hE0,
                  8'h08, 8'h02, 8'h00, 8'h00, 8'h00};
  logic [31:0] typs [4] = '{T_IDAT, 32'h7445_5874, 32'h504C_5445, T_IDAT};

  always @(negedge clk) begin
    if (!rst) begin
      if (val_o) got_pay.push_back({lst_o, dat_o});
      if (hdr_val_o) begin
        got_typ.push_back(typ_o);
        got_len.push_back(len_o);
      end
      if (crc_val_o) got_crc.push_back(crc_err_o);
      if (done_o) begin
        if (crc_val_o && !crc_err_o) got_done++;
        else got_done_bad++;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_model(input bq_t q);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (q[i]) c = crc_tab[c[7:0] ^ q[i]] ^ (c >> 8);
    return ~c;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    val_i = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    val_i = 1'b1;
    dat_i = b;
    @(posedge clk); #1;
    val_i = 1'b0;
    dat_i = 8'($urandom);
  endtask

  task automatic send_q(input bq_t q, input int unsigned maxgap);
    foreach (q[i]) send_byte(q[i], $urandom_range(0, maxgap));
  endtask

  task automatic do_start();
    start_i = 1'b1;
    val_i   = 1'b1;
    dat_i   = 8'h89;
    @(posedge clk); #1;
    start_i = 1'b0;
    val_i   = 1'b0;
  endtask

  task automatic begin_scn();
    b_pay  = got_pay.size();
    b_hdr  = got_typ.size();
    b_crc  = got_crc.size();
    b_done = got_done;
    exp_pay.delete();
    exp_typ.delete();
    exp_len.delete();
    exp_crc.delete();
    strm.delete();
  endtask

  task automatic add_chunk(input logic [31:0] typ, input bq_t data,
                           input bit corrupt, input bit live);
    bq_t body;
    logic [31:0] len, crc;
    len = 32'(data.size());
    body.push_back(typ[31:24]);
    body.push_back(typ[23:16]);
    body.push_back(typ[15:8]);
    body.push_back(typ[7:0]);
    foreach (data[i]) body.push_back(data[i]);
    crc = crc_model(body);
    if (corrupt) crc[0] = ~crc[0];
    strm.push_back(len[31:24]);
    strm.push_back(len[23:16]);
    strm.push_back(len[15:8]);
    strm.push_back(len[7:0]);
    foreach (body[i]) strm.push_back(body[i]);
    strm.push_back(crc[31:24]);
    strm.push_back(crc[23:16]);
    strm.push_back(crc[15:8]);
    strm.push_back(crc[7:0]);
    if (live) begin
      exp_typ.push_back(typ);
      exp_len.push_back(len);
      if (typ == T_IDAT) begin
        foreach (data[i]) exp_pay.push_back({(i == data.size() - 1), data[i]});
      end
      exp_crc.push_back(corrupt);
    end
  endtask

  task automatic check_events(input string tag, input logic [1:0] exp_code,
                              input logic exp_e, input int exp_done);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk({tag, "/pay_n"}, 64'(got_pay.size() - b_pay), 64'(exp_pay.size()));
    for (int i = 0; i < exp_pay.size() && b_pay + i < got_pay.size(); i++)
      chk({tag, "/pay"}, 64'(got_pay[b_pay + i]), 64'(exp_pay[i]));
    chk({tag, "/hdr_n"}, 64'(got_typ.size() - b_hdr), 64'(exp_typ.size()));
    for (int i = 0; i < exp_typ.size() && b_hdr + i < got_typ.size(); i++) begin
      chk({tag, "/typ"}, 64'(got_typ[b_hdr + i]), 64'(exp_typ[i]));
      chk({tag, "/len"}, 64'(got_len[b_hdr + i]), 64'(exp_len[i]));
    end
    chk({tag, "/crc_n"}, 64'(got_crc.size() - b_crc), 64'(exp_crc.size()));
    for (int i = 0; i < exp_crc.size() && b_crc + i < got_crc.size(); i++)
      chk({tag, "/crc_err"}, 64'(got_crc[b_crc + i]), 64'(exp_crc[i]));
    chk({tag, "/done_n"}, 64'(got_done - b_done), 64'(exp_done));
    chk({tag, "/done_align"}, 64'(got_done_bad), 64'd0);
    chk({tag, "/err"}, 64'(err_o), 64'(exp_e));
    chk({tag, "/code"}, 64'(err_code_o), 64'(exp_code));
    chk({tag, "/busy"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    int unsigned nch, bad, dl;
    bit live;
    logic [31:0] t;

    for (int n = 0; n < 256; n++) begin
      logic [31:0] c;
      c = 32'(n);
      for (int k = 0; k < 8; k++) c = c[0] ? (32'hEDB8_8320 ^ (c >> 1)) : (c >> 1);
      crc_tab[n] = c;
    end

    // Reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst/busy", 64'(busy_o), 64'd0);
    chk("rst/err", 64'(err_o), 64'd0);
    chk("rst/code", 64'(err_code_o), 64'd0);
    chk("rst/typ", 64'(typ_o), 64'd0);
    chk("rst/len", 64'(len_o), 64'd0);
    chk("rst/w", 64'(w_o), 64'd0);
    chk("rst/h", 64'(h_o), 64'd0);
    chk("rst/hdr_val", 64'(hdr_val_o), 64'd0);
    chk("rst/val", 64'(val_o), 64'd0);
    chk("rst/crc_val", 64'(crc_val_o), 64'd0);
    chk("rst/done", 64'(done_o), 64'd0);

    // Minimal stream: signature + literal IEND chunk
    begin_scn();
    do_start();
    chk("start/busy", 64'(busy_o), 64'd1);
    chk("start/err", 64'(err_o), 64'd0);
    strm = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h49, 8'h45, 8'h4E, 8'h44,
             8'hAE, 8'h42, 8'h60, 8'h82};
    exp_typ.push_back(T_IEND);
    exp_len.push_back(32'd0);
    exp_crc.push_back(1'b0);
    send_q(sig_q, 1);
    send_q(strm, 1);
    check_events("iend", 2'd0, 1'b0, 1);

    // Bad second signature byte
    begin_scn();
    do_start();
    send_byte(8'h89, 0);
    chk("sig/err_before", 64'(err_o), 64'd0);
    send_byte(8'h51, 0);
    chk("sig/err_next", 64'(err_o), 64'd1);
    chk("sig/code_next", 64'(err_code_o), 64'd1);
    dq.delete();
    add_chunk(T_IEND, dq, 1'b0, 1'b0);
    for (int i = 2; i < 8; i++) send_byte(sig_q[i], 0);
    send_q(strm, 1);
    check_events("sig", 2'd1, 1'b1, 0);

    // IEND with stored CRC off by one
    begin_scn();
    do_start();
    dq.delete();
    add_chunk(T_IEND, dq, 1'b1, 1'b1);
    send_q(sig_q, 1);
    send_q(strm, 1);
    check_events("iend_bad", 2'd2, 1'b1, 0);

    // IDAT payload with gaps, then IEND
    begin_scn();
    do_start();
    dq = '{8'h01, 8'h02, 8'h03};
    add_chunk(T_IDAT, dq, 1'b0, 1'b1);
    dq.delete();
    add_chunk(T_IEND, dq, 1'b0, 1'b1);
    send_q(sig_q, 2);
    send_q(strm, 3);
    check_events("idat", 2'd0, 1'b0, 1);

    // IHDR size capture, then an oversize length
    begin_scn();
    do_start();
    add_chunk(T_IHDR, ihdr_q, 1'b0, 1'b1);
    send_q(sig_q, 1);
    for (int i = 0; i < 16; i++) send_byte(strm[i], $urandom_range(0, 1));
    chk("ihdr/w", 64'(w_o), 64'd640);
    chk("ihdr/h", 64'(h_o), 64'd480);
    for (int i = 16; i < strm.size(); i++) send_byte(strm[i], $urandom_range(0, 1));
    send_byte(8'h80, 0);
    send_byte(8'h00, 1);
    send_byte(8'h00, 0);
    chk("len/err_early", 64'(err_o), 64'd0);
    send_byte(8'h00, 0);
    chk("len/err", 64'(err_o), 64'd1);
    chk("len/code", 64'(err_code_o), 64'd3);
    check_events("ihdr", 2'd3, 1'b1, 0);

    // Restart in the middle of IDAT data
    begin_scn();
    do_start();
    add_chunk(T_IHDR, ihdr_q, 1'b0, 1'b1);
    send_q(sig_q, 1);
    send_q(strm, 1);
    chk("mid/w_before", 64'(w_o), 64'd640);
    dq = '{8'h00, 8'h00, 8'h00, 8'h05, 8'h49, 8'h44, 8'h41, 8'h54, 8'hAA, 8'hBB};
    send_q(dq, 1);
    exp_typ.push_back(T_IDAT);
    exp_len.push_back(32'd5);
    exp_pay.push_back({1'b0, 8'hAA});
    exp_pay.push_back({1'b0, 8'hBB});
    do_start();
    chk("mid/w_clr", 64'(w_o), 64'd0);
    chk("mid/h_clr", 64'(h_o), 64'd0);
    chk("mid/err", 64'(err_o), 64'd0);
    chk("mid/busy", 64'(busy_o), 64'd1);
    strm.delete();
    dq.delete();
    add_chunk(T_IEND, dq, 1'b0, 1'b1);
    send_q(sig_q, 1);
    send_q(strm, 1);
    check_events("restart", 2'd0, 1'b0, 1);

    // Random chunk sequences, optionally one corrupted CRC
    for (int r = 0; r < 8; r++) begin
      begin_scn();
      do_start();
      nch  = $urandom_range(1, 4);
      bad  = $urandom_range(0, nch + 1);
      live = 1'b1;
      for (int k = 0; k < nch; k++) begin
        t  = typs[$urandom_range(0, 3)];
        dl = $urandom_range(0, 6);
        dq.delete();
        for (int j = 0; j < dl; j++) dq.push_back(8'($urandom));
        add_chunk(t, dq, (k == bad), live);
        if (k == bad) live = 1'b0;
      end
      dq.delete();
      add_chunk(T_IEND, dq, (bad == nch), live);
      send_q(sig_q, 2);
      send_q(strm, 2);
      if (bad <= nch) check_events("rand_bad", 2'd2, 1'b1, 0);
      else check_events("rand_ok", 2'd0, 1'b0, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
